// File: rtl/bcd_counter_modn.sv
// N-digit BCD up/down counter with runtime modulus, synchronous load, prescaler tick
// and registered active-low 7-segment decode per digit.
module bcd_counter_modn #(
  parameter int NUM_DIGITS = 3,
  parameter int DIV_COEFF  = 50_000_000,
  parameter int DIV_W      = 26
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cnt_en,
  input  logic                    cnt_dir,
  input  logic                    cnt_load,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic [4*NUM_DIGITS-1:0] mod_bcd,
  output logic [4*NUM_DIGITS-1:0] cnt_bcd,
  output logic [7*NUM_DIGITS-1:0] seg_n,
  output logic                    tick,
  output logic                    wrap,
  output logic                    load_err
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COEFF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BW-1:0]    mod_sat;
  logic [BW-1:0]    cnt_inc;
  logic [BW-1:0]    cnt_dec;
  logic [BW-1:0]    cnt_next;
  logic             wrap_next;
  logic             err_next;
  logic             load_ok;
  logic             carry;
  logic             borrow;
  logic [7*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Prescaler free-runs regardless of enable/load/direction; tick is a clock enable.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Non-BCD modulus digits are clamped to 9 so the count can never hold an illegal digit.
  always_comb begin
    load_ok = 1'b1;
    mod_sat = mod_bcd;
    cnt_inc = cnt_bcd;
    cnt_dec = cnt_bcd;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_bcd[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (mod_bcd[4*i +: 4] > 4'd9) mod_sat[4*i +: 4] = 4'd9;
      if (carry) begin
        if (cnt_bcd[4*i +: 4] >= 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_bcd[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = cnt_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Load (even a rejected one) takes priority over a count step.
  always_comb begin
    cnt_next  = cnt_bcd;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (cnt_load) begin
      if (load_ok) cnt_next = load_bcd;
      else         err_next = 1'b1;
    end else if (tick && cnt_en) begin
      if (cnt_dir) begin
        if (cnt_bcd >= mod_sat) begin
          cnt_next  = '0;
          wrap_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end else begin
        if (cnt_bcd == '0) begin
          cnt_next  = mod_sat;
          wrap_next = 1'b1;
        end else if (cnt_bcd > mod_sat) begin
          cnt_next = mod_sat;
        end else begin
          cnt_next = cnt_dec;
        end
      end
    end
  end

  always_comb begin
    seg_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_next[7*i +: 7] = seg_decode(cnt_bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_bcd  <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      seg_n    <= {NUM_DIGITS{7'h40}};
    end else begin
      cnt_bcd  <= cnt_next;
      wrap     <= wrap_next;
      load_err <= err_next;
      seg_n    <= seg_next;
    end
  end

endmodule
